// File: rtl/br_pht_updater.sv
// br_pht_updater: queues resolved branches and applies saturating 2-bit counter updates to a pattern table.
// Optional BR_PHT_SKIP_SAT_EN suppresses the write strobe when a counter is already saturated.
module br_pht_updater #(
    parameter int SET_W  = 4,
    parameter int TAB_W  = 4,
    parameter int DATA_W = 2,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [SET_W-1:0]  res_set,
    input  logic [TAB_W-1:0]  res_tab,
    input  logic              res_taken,
    output logic [SET_W-1:0]  tab_set_addr,
    output logic [TAB_W-1:0]  tab_tab_addr,
    input  logic [DATA_W-1:0] tab_rd_data,
    output logic              tab_wr_en,
    output logic [DATA_W-1:0] tab_up_data,
    output logic              busy
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int EW = SET_W + TAB_W + 1;
    localparam logic [DATA_W-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state;
    logic [EW-1:0]     mem [QDEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              push, pop, full, skip, active;
    logic [SET_W-1:0]  head_set, hold_set;
    logic [TAB_W-1:0]  head_tab, hold_tab;
    logic              head_taken, hold_taken;
    logic [DATA_W-1:0] cur, next;

    assign full      = count == (AW+1)'(QDEPTH);
    assign res_ready = !reset && !full;
    assign push      = res_valid && res_ready;
    // count is registered, so a record pushed this cycle is only visible to IDLE next cycle
    assign pop       = state == IDLE && count != '0;
    assign {head_set, head_tab, head_taken} = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {res_set, res_tab, res_taken};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_set   <= '0;
            hold_tab   <= '0;
            hold_taken <= 1'b0;
            cur        <= '0;
        end else begin
            state <= (state == IDLE && pop) ? READ : (state == READ) ? WRITE : IDLE;
            if (pop) {hold_set, hold_tab, hold_taken} <= {head_set, head_tab, head_taken};
            if (state == READ) cur <= tab_rd_data;
        end
    end

    assign next = hold_taken ? ((cur == MAX) ? cur : cur + 1'b1)
                             : ((cur == '0) ? cur : cur - 1'b1);

`ifdef BR_PHT_SKIP_SAT_EN
    assign skip = next == cur;
`else
    assign skip = 1'b0;
`endif

    // reset masks the outputs combinationally so an in-flight WRITE never strobes
    assign active       = !reset && state != IDLE;
    assign busy         = active;
    assign tab_set_addr = active ? hold_set : '0;
    assign tab_tab_addr = active ? hold_tab : '0;
    assign tab_wr_en    = active && state == WRITE && !skip;
    assign tab_up_data  = (active && state == WRITE) ? next : '0;
endmodule

// File: tb/tb_br_pht_updater.sv
// tb_br_pht_updater: directed stimulus against a queue-and-table reference model of br_pht_updater.
module tb_br_pht_updater;
    logic       clk = 1'b0, reset = 1'b1;
    logic       res_valid = 1'b0, res_taken = 1'b0;
    logic       res_ready, tab_wr_en, busy;
    logic [3:0] res_set = '0, res_tab = '0, tab_set_addr, tab_tab_addr;
    logic [1:0] tab_rd_data, tab_up_data;

    typedef struct packed {logic [3:0] s; logic [3:0] t; logic k;} rec_t;

    logic [1:0] env_tab   [16][16];
    logic [1:0] model_tab [16][16];
    rec_t       exp_q [$];
    int         errors = 0, checks = 0, cyc = 0, last_wr = -100, accepted;

    br_pht_updater dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
        .res_set(res_set), .res_tab(res_tab), .res_taken(res_taken),
        .tab_set_addr(tab_set_addr), .tab_tab_addr(tab_tab_addr), .tab_rd_data(tab_rd_data),
        .tab_wr_en(tab_wr_en), .tab_up_data(tab_up_data), .busy(busy)
    );

    assign tab_rd_data = env_tab[tab_set_addr][tab_tab_addr];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        return (v > 3) ? 2'd3 : (v < 0) ? 2'd0 : 2'(v);
    endfunction

    // per-cycle comparison of DUT outputs against the reference model
    task automatic check_cycle();
        rec_t r;
        logic [1:0] e;
        cyc++;
        if (reset) begin
            check("reset_outputs", {res_ready, tab_wr_en, busy, tab_set_addr, tab_tab_addr, tab_up_data}, 0);
        end else begin
            if (!busy) check("idle_outputs", {tab_wr_en, tab_set_addr, tab_tab_addr}, 0);
            if (tab_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    e = sat(model_tab[r.s][r.t], r.k);
                    model_tab[r.s][r.t] = e;
                    check("write_set", tab_set_addr, r.s);
                    check("write_tab", tab_tab_addr, r.t);
                    check("write_data", tab_up_data, e);
                    check("write_gap_ge3", (cyc - last_wr) >= 3, 1);
                end
                last_wr = cyc;
                env_tab[tab_set_addr][tab_tab_addr] = tab_up_data;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic preload(input int s, input int t, input logic [1:0] v);
        env_tab[s][t] = v;
        model_tab[s][t] = v;
    endtask

    task automatic offer(input int s, input int t, input logic k);
        res_valid = 1'b1;
        res_set   = 4'(s);
        res_tab   = 4'(t);
        res_taken = k;
        if (res_ready) begin
            exp_q.push_back('{s: 4'(s), t: 4'(t), k: k});
            accepted++;
        end
    endtask

    task automatic idle();
        res_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        check("drain_done", exp_q.size(), 0);
        step();
        step();
    endtask

    initial begin
        logic [8:0] burst_ready;
        burst_ready = 9'b1_0011_1111;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) preload(i, j, 2'd0);

        repeat (3) step();
        reset = 1'b0;
        #1 check("ready_after_reset", res_ready, 1);

        // single record: write lands three cycles after acceptance
        preload(3, 5, 2'b01);
        offer(3, 5, 1'b1);
        step(); idle();
        check("lat_c1_wr_en", tab_wr_en, 0);
        check("lat_c1_busy", busy, 0);
        step();
        check("lat_c2_busy", busy, 1);
        check("lat_c2_wr_en", tab_wr_en, 0);
        check("lat_c2_addr", {tab_set_addr, tab_tab_addr}, {4'd3, 4'd5});
        step();
        check("lat_c3_wr_en", tab_wr_en, 1);
        check("lat_c3_addr", {tab_set_addr, tab_tab_addr}, {4'd3, 4'd5});
        check("lat_c3_data", tab_up_data, 2'b10);
        step();
        check("lat_c4_busy", busy, 0);

        // saturation at both ends
        preload(1, 2, 2'b11);
        offer(1, 2, 1'b1);
        step(); idle(); step(); step();
        check("sat_hi_wr_en", tab_wr_en, 1);
        check("sat_hi_data", tab_up_data, 2'b11);
        step();
        preload(2, 3, 2'b00);
        offer(2, 3, 1'b0);
        step(); idle(); step(); step();
        check("sat_lo_wr_en", tab_wr_en, 1);
        check("sat_lo_data", tab_up_data, 2'b00);
        step();

        // back-to-back to one address must see the prior write
        offer(4, 4, 1'b1);
        step();
        offer(4, 4, 1'b1);
        step(); idle();
        drain();
        check("same_addr_final", env_tab[4][4], 2'b10);

        // sustained valid: fills, refuses while full even during a pop, resumes next cycle
        accepted = 0;
        for (int i = 0; i < 9; i++) begin
            offer(i, 15 - i, i[0]);
            check($sformatf("burst_ready_%0d", i), res_ready, burst_ready[i]);
            step();
        end
        idle();
        check("burst_accepted", accepted, 7);
        drain();

        // reset during WRITE with two records still queued
        offer(10, 1, 1'b1); step();
        offer(10, 2, 1'b1); step();
        offer(10, 3, 1'b0); step(); idle();
        for (int i = 0; i < 10 && !tab_wr_en; i++) step();
        check("rst_mid_saw_write", tab_wr_en, 1);
        check("rst_mid_queued", exp_q.size(), 2);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_wr_en", tab_wr_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", res_ready, 0);
        exp_q.delete();
        step(); step();
        reset = 1'b0;
        #1 check("rst_mid_ready_after", res_ready, 1);
        repeat (12) step();
        check("rst_mid_no_write_2", env_tab[10][2], 2'b00);
        check("rst_mid_no_write_3", env_tab[10][3], 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
